// File: rtl/sram_access_ctrl_if.sv
// Method-call side of the SRAM controller: memRead/memWrite request, ready and return signals.
interface sram_access_ctrl_if;
   logic        mem_rd_en;
   logic [20:0] mem_rd_arg;
   logic        mem_rd_rdy;
   logic [15:0] mem_rd_dat;
   logic        mem_rd_vld;
   logic        mem_wr_en;
   logic [36:0] mem_wr_arg;
   logic        mem_wr_rdy;

   modport slave (
      input  mem_rd_en, mem_rd_arg, mem_wr_en, mem_wr_arg,
      output mem_rd_rdy, mem_rd_dat, mem_rd_vld, mem_wr_rdy
   );

   modport master (
      output mem_rd_en, mem_rd_arg, mem_wr_en, mem_wr_arg,
      input  mem_rd_rdy, mem_rd_dat, mem_rd_vld, mem_wr_rdy
   );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences single-word reads/writes to an async 16-bit SRAM with WAIT_CYCLES extra access cycles.
// Every output is registered from the next state, so the pins change exactly on state boundaries.
module sram_access_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               CLK,
   input  logic               RESET,
   sram_access_ctrl_if.slave  mem,
   output logic [ADDR_W-1:0]  sram_addr,
   output logic [DATA_W-1:0]  sram_dout,
   input  logic [DATA_W-1:0]  sram_din,
   output logic               sram_oe_drv,
   output logic               SRAM_CE,
   output logic               SRAM_OE,
   output logic               SRAM_WE,
   output logic               SRAM_LB,
   output logic               SRAM_UB
);

   typedef enum logic [2:0] {IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;
   logic                ready, ready_nxt;
   logic                valid, valid_nxt;
   logic [DATA_W-1:0]   ret, ret_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   dout_nxt;
   logic                lb_nxt, ub_nxt, ce_nxt, oe_nxt, we_nxt, drv_nxt;
   logic                unused_arg_bits;

   assign unused_arg_bits = ^{mem.mem_rd_arg[4:0], mem.mem_wr_arg[4:2]};

   assign mem.mem_rd_rdy = ready;
   assign mem.mem_wr_rdy = ready;
   assign mem.mem_rd_vld = valid;
   assign mem.mem_rd_dat = ret;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = sram_addr;
      dout_nxt  = sram_dout;
      lb_nxt    = SRAM_LB;
      ub_nxt    = SRAM_UB;
      ret_nxt   = ret;
      valid_nxt = 1'b0;
      case (state)
         IDLE: begin
            // Write has priority; a simultaneous read is dropped and must be re-presented.
            if (ready && mem.mem_wr_en) begin
               state_nxt = WR_SETUP;
               addr_nxt  = mem.mem_wr_arg[5 +: ADDR_W];
               dout_nxt  = mem.mem_wr_arg[21 +: DATA_W];
               lb_nxt    = ~mem.mem_wr_arg[0];
               ub_nxt    = ~mem.mem_wr_arg[1];
            end else if (ready && mem.mem_rd_en) begin
               state_nxt = RD_ACC;
               cnt_nxt   = WAIT_INIT;
               addr_nxt  = mem.mem_rd_arg[5 +: ADDR_W];
               lb_nxt    = 1'b0;
               ub_nxt    = 1'b0;
            end
         end
         RD_ACC: begin
            if (cnt == 4'd0) begin
               state_nxt = IDLE;
               ret_nxt   = sram_din;
               valid_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         WR_SETUP: begin
            state_nxt = WR_PULSE;
            cnt_nxt   = WAIT_INIT;
         end
         WR_PULSE: begin
            if (cnt == 4'd0) state_nxt = WR_HOLD;
            else             cnt_nxt   = cnt - 4'd1;
         end
         WR_HOLD:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase

      if (state_nxt == IDLE) begin
         lb_nxt = 1'b1;
         ub_nxt = 1'b1;
      end
      ready_nxt = (state_nxt == IDLE);
      ce_nxt    = (state_nxt == IDLE);
      oe_nxt    = (state_nxt != RD_ACC);
      we_nxt    = (state_nxt != WR_PULSE);
      drv_nxt   = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         ready       <= 1'b0;
         valid       <= 1'b0;
         ret         <= '0;
         sram_addr   <= '0;
         sram_dout   <= '0;
         sram_oe_drv <= 1'b0;
         SRAM_CE     <= 1'b1;
         SRAM_OE     <= 1'b1;
         SRAM_WE     <= 1'b1;
         SRAM_LB     <= 1'b1;
         SRAM_UB     <= 1'b1;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         ready       <= ready_nxt;
         valid       <= valid_nxt;
         ret         <= ret_nxt;
         sram_addr   <= addr_nxt;
         sram_dout   <= dout_nxt;
         sram_oe_drv <= drv_nxt;
         SRAM_CE     <= ce_nxt;
         SRAM_OE     <= oe_nxt;
         SRAM_WE     <= we_nxt;
         SRAM_LB     <= lb_nxt;
         SRAM_UB     <= ub_nxt;
      end
   end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequences single-word accesses to the external 16-bit asynchronous SRAM on behalf of the Kami-generated design's memRead/memWrite methods.
- Sits between _design and the SB_IO pad/pin layer.
- Converts one-cycle method calls into timed CE/OE/WE/byte-lane pin sequences with programmable wait states.
- Captures read data and returns it with a valid pulse.

Parameters:
- ADDR_W, 16, SRAM address width in words.
- DATA_W, 16, SRAM data width (fixed 16; LB/UB lanes assume it).
- WAIT_CYCLES, 1, extra access cycles beyond the minimum (legal 0..15).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- memRead$_enable  input  1  read request.
- memRead$_argument  input  21  [20:5] word address; [4:0] ignored.
- memRead$_ready  output  1  controller idle; a request is accepted when enable && ready.
- memRead$_return  output  16  captured read data; holds until the next read completes.
- memRead$_valid  output  1  one-cycle pulse; memRead$_return is new.
- memWrite$_enable  input  1  write request.
- memWrite$_argument  input  37  [36:21] data; [20:5] word address; [1:0] byte enables (bit0 low byte, bit1 high byte, active high); [4:2] ignored.
- memWrite$_ready  output  1  identical to memRead$_ready.
- sram_addr  output  ADDR_W  address to pins.
- sram_dout  output  16  write data to pad D_OUT_0.
- sram_din  input  16  pad D_IN_0.
- sram_oe_drv  output  1  pad OUTPUT_ENABLE; high drives the data pins.
- SRAM_CE, SRAM_OE, SRAM_WE, SRAM_LB, SRAM_UB  output  1 each  active-low SRAM strobes.

Behaviour:
- All outputs are registered.
- Reset values: SRAM_CE/OE/WE/LB/UB = 1; sram_oe_drv = 0; sram_addr = 0; sram_dout = 0; memRead$_return = 0; memRead$_valid = 0; ready = 0; state = IDLE.
- Ready rises in the first cycle after RESET deasserts.
- States: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD. A wait counter of 4 bits counts down from WAIT_CYCLES.
- IDLE:
  - ready = 1; all strobes high; sram_oe_drv = 0.
  - If write enable is high, accept the write, latch argument fields, and go to WR_SETUP. Write wins if both requests are enabled in the same cycle; the read is not accepted and must be re-presented.
  - Else if read enable is high, latch the address and go to RD_ACC.
  - ready drops in the cycle after acceptance.
- RD_ACC:
  - Lasts WAIT_CYCLES+1 cycles.
  - Pins: sram_addr = latched address; CE = OE = LB = UB = 0; WE = 1; sram_oe_drv = 0.
  - On the final edge, load sram_din into memRead$_return and go to IDLE.
  - memRead$_valid = 1 and ready = 1 in that IDLE cycle.
  - Latency: accept edge to valid cycle = WAIT_CYCLES+2 cycles.
- WR_SETUP:
  - 1 cycle.
  - Pins: addr and data driven; sram_oe_drv = 1; CE = 0; WE = 1; OE = 1.
  - LB = ~be[0]; UB = ~be[1].
- WR_PULSE:
  - WAIT_CYCLES+1 cycles.
  - Same as WR_SETUP except WE = 0.
- WR_HOLD:
  - 1 cycle.
  - WE = 1; addr, data, sram_oe_drv and byte lanes held.
  - Then IDLE with sram_oe_drv = 0.
  - Write occupancy = WAIT_CYCLES+3 cycles.
- Byte enables 2'b00: the sequence still runs, but LB = UB = 1, so no byte is written.
- OE and WE are never both low. sram_oe_drv is high only in write states.
- Requests arriving while ready = 0 are ignored (not queued).
- Address and data are taken only at acceptance; argument changes mid-access have no effect.
- RESET asserted mid-access:
  - Immediately forces the reset values: WE high, sram_oe_drv low.
  - No valid pulse; memRead$_return is cleared.
- Back-to-back: a request may be accepted in the same cycle memRead$_valid is high.

Test Plan:
- Reset release, no requests → ready = 0 during reset, 1 one cycle after release; all strobes 1; sram_oe_drv = 0.
- WAIT_CYCLES=1, write addr 0x1234, data 0xBEEF, be = 2'b11 → WR_SETUP 1 cycle, WE = 0 for exactly 2 cycles, hold 1 cycle; sram_oe_drv high 4 cycles; ready low 4 cycles.
- Read addr 0x1234, SRAM model returns 0xBEEF → OE = 0 for 2 cycles; memRead$_return = 0xBEEF with a one-cycle valid 3 cycles after acceptance.
- Write and read enabled in the same cycle (write 0x0001 → 0x00A5, read 0x0002) → write executes; read not accepted; re-presented read then returns 0x0002 contents.
- Write be = 2'b01, data 0xFFFF, over location 0x1234 → LB = 0, UB = 1 during the pulse; subsequent read returns 0xBEFF.
- RESET asserted during the WR_PULSE cycle → WE = 1 and sram_oe_drv = 0 in the same cycle (asynchronous); no valid pulse; after release, state IDLE and ready = 1.
